// File: rtl/uart_fifo_ctrl.sv
// Buffered UART front-end: TX FIFO drained by a load/busy sequencer, RX FIFO filled from the core.
// Status and RX head are combinational from registered state; TX writes stall via reg_dat_wait_o while full.
module uart_fifo_ctrl #(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        reg_state_we_i,
    input  logic        reg_state_re_i,
    input  logic [31:0] reg_state_di_i,
    output logic [31:0] reg_state_do_o,
    output logic        reg_state_wait_o,
    input  logic        reg_dat_we_i,
    input  logic        reg_dat_re_i,
    input  logic [31:0] reg_dat_di_i,
    output logic [31:0] reg_dat_do_o,
    output logic        reg_dat_wait_o,
    output logic        uart_load_o,
    output logic [7:0]  uart_d_o,
    input  logic        uart_txbusy_i,
    input  logic        uart_bytercvd_i,
    input  logic [7:0]  uart_q_i
);
    localparam int TXD = 1 << TX_DEPTH_LOG2;
    localparam int RXD = 1 << RX_DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE} tx_state_e;

    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] rx_level;
        logic [7:0] tx_level;
        logic [2:0] rsvd_lo;
        logic       rx_overrun;
        logic       tx_idle;
        logic       tx_empty;
        logic       rx_valid;
        logic       tx_full;
    } status_t;

    logic [7:0]             tx_mem_q [TXD];
    logic [7:0]             rx_mem_q [RXD];
    logic [TX_DEPTH_LOG2:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_level;
    logic [RX_DEPTH_LOG2:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_level;
    logic                   overrun_q, overrun_d;
    tx_state_e              state_q, state_d;
    logic [1:0]             guard_q, guard_d;
    logic [7:0]             uart_d_q, uart_d_d;
    logic                   tx_full, tx_empty, rx_full, rx_empty;
    logic                   tx_flush, rx_flush, ovr_clr;
    logic                   tx_push, tx_start, rx_push, rx_pop, rx_ovf, tx_idle;
    logic [7:0]             tx_head, rx_head;
    status_t                status;
    logic                   unused_ok;

    assign tx_level = tx_wr_q - tx_rd_q;
    assign rx_level = rx_wr_q - rx_rd_q;
    assign tx_full  = (tx_level == (TX_DEPTH_LOG2+1)'(TXD));
    assign rx_full  = (rx_level == (RX_DEPTH_LOG2+1)'(RXD));
    assign tx_empty = (tx_level == '0);
    assign rx_empty = (rx_level == '0);
    assign tx_head  = tx_mem_q[tx_rd_q[TX_DEPTH_LOG2-1:0]];
    assign rx_head  = rx_mem_q[rx_rd_q[RX_DEPTH_LOG2-1:0]];

    assign tx_flush = reg_state_we_i && reg_state_di_i[8];
    assign rx_flush = reg_state_we_i && reg_state_di_i[9];
    assign ovr_clr  = reg_state_we_i && reg_state_di_i[4];

    // Flushes win over any push/pop on the same FIFO in the same cycle.
    assign tx_push  = reg_dat_we_i && !tx_full && !tx_flush;
    assign tx_start = (state_q == S_IDLE) && !tx_empty && !uart_txbusy_i && !tx_flush;
    assign rx_pop   = reg_dat_re_i && !rx_empty && !rx_flush;
    assign rx_push  = uart_bytercvd_i && !rx_flush && (!rx_full || rx_pop);
    assign rx_ovf   = uart_bytercvd_i && !rx_flush && rx_full && !rx_pop;

    always_comb begin
        tx_wr_d   = tx_wr_q;
        tx_rd_d   = tx_rd_q;
        rx_wr_d   = rx_wr_q;
        rx_rd_d   = rx_rd_q;
        overrun_d = overrun_q;
        if (tx_flush) begin
            tx_rd_d = tx_wr_q;
        end else begin
            if (tx_push)  tx_wr_d = tx_wr_q + 1'b1;
            if (tx_start) tx_rd_d = tx_rd_q + 1'b1;
        end
        if (rx_flush) begin
            rx_rd_d = rx_wr_q;
        end else begin
            if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;
        end
        if (rx_ovf)       overrun_d = 1'b1;
        else if (ovr_clr) overrun_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wr_q[TX_DEPTH_LOG2-1:0]] <= reg_dat_di_i[7:0];
        if (rx_push) rx_mem_q[rx_wr_q[RX_DEPTH_LOG2-1:0]] <= uart_q_i;
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            overrun_q <= 1'b0;
            state_q   <= S_IDLE;
            guard_q   <= '0;
            uart_d_q  <= '0;
        end else begin
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
            guard_q   <= guard_d;
            uart_d_q  <= uart_d_d;
        end
    end

    // WAIT_BUSY gives up after four quiet cycles so a core that never raises busy cannot hang us.
    always_comb begin
        state_d  = state_q;
        guard_d  = guard_q;
        uart_d_d = uart_d_q;
        unique case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    uart_d_d = tx_head;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                guard_d = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_txbusy_i)       state_d = S_WAIT_DONE;
                else if (guard_q == 2'd3) state_d = S_IDLE;
                else                     guard_d = guard_q + 2'd1;
            end
            S_WAIT_DONE: begin
                if (!uart_txbusy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        uart_load_o = (state_q == S_LOAD);
        tx_idle     = tx_empty && (state_q == S_IDLE) && !uart_txbusy_i;
    end

    always_comb begin
        status            = '0;
        status.tx_full    = tx_full;
        status.rx_valid   = !rx_empty;
        status.tx_empty   = tx_empty;
        status.tx_idle    = tx_idle;
        status.rx_overrun = overrun_q;
        status.tx_level   = 8'(tx_level);
        status.rx_level   = 8'(rx_level);
    end

    assign uart_d_o         = uart_d_q;
    assign reg_state_do_o   = status;
    assign reg_state_wait_o = 1'b0;
    assign reg_dat_wait_o   = reg_dat_we_i && tx_full;
    assign reg_dat_do_o     = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_head};

    assign unused_ok = ^{reg_dat_di_i[31:8], reg_state_di_i[31:10], reg_state_di_i[7:5],
                         reg_state_di_i[3:0], reg_state_re_i};
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: directed scenarios plus randomized RX/TX traffic against a queue model.
module tb_uart_fifo_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        st_we, st_re, dat_we, dat_re;
    logic [31:0] st_di, st_do, dat_di, dat_do;
    logic        st_wait, dat_wait;
    logic        uload;
    logic [7:0]  ud;
    logic        txbusy;
    logic        rcvd;
    logic [7:0]  rq;

    int total = 0;
    int bad   = 0;

    // Core model: busy for core_len cycles after each sampled load pulse.
    int        cyc = 0;
    int        busy_cnt = 0;
    int        core_len = 20;
    logic      force_busy = 1'b0;
    logic [7:0] loads_q[$];
    int        load_cyc_q[$];

    uart_fifo_ctrl #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .reg_state_we_i(st_we), .reg_state_re_i(st_re), .reg_state_di_i(st_di),
        .reg_state_do_o(st_do), .reg_state_wait_o(st_wait),
        .reg_dat_we_i(dat_we), .reg_dat_re_i(dat_re), .reg_dat_di_i(dat_di),
        .reg_dat_do_o(dat_do), .reg_dat_wait_o(dat_wait),
        .uart_load_o(uload), .uart_d_o(ud), .uart_txbusy_i(txbusy),
        .uart_bytercvd_i(rcvd), .uart_q_i(rq)
    );

    always #5 clk = ~clk;

    assign txbusy = force_busy || (busy_cnt > 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uload) begin
            loads_q.push_back(ud);
            load_cyc_q.push_back(cyc);
            busy_cnt <= core_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        st_we = 0; st_re = 0; st_di = 0;
        dat_we = 0; dat_re = 0; dat_di = 0;
        rcvd = 0; rq = 0;
    endtask

    // Random-phase model state
    logic [7:0] rxm[$];
    logic [7:0] exp_tx[$];
    logic       ovr_m;

    initial begin
        int n;
        logic accepted;
        idle_inputs();
        resetn = 0;

        // Reset state
        step(); step();
        check_val("rst_stat", st_do, 32'h0000_000C);
        check_val("rst_dat", dat_do, 32'hFFFF_FFFF);
        check_val("rst_load", uload, 0);
        check_val("rst_d", ud, 8'h00);
        force_busy = 1; #1;
        check_val("rst_stat_busy", st_do, 32'h0000_0004);
        force_busy = 0;
        resetn = 1;
        for (int i = 0; i < 10; i++) step();
        check_val("idle_noload", loads_q.size(), 0);
        check_val("idle_wait", st_wait, 0);

        // Three back-to-back bytes, first one checked for latency
        dat_we = 1; dat_di = 32'h41;
        step();
        check_val("lat_n", uload, 0);
        dat_di = 32'h42;
        step();
        check_val("lat_n1_load", uload, 1);
        check_val("lat_n1_d", ud, 8'h41);
        dat_di = 32'h43;
        step();
        dat_we = 0;
        n = 0;
        while (!(loads_q.size() == 3 && st_do[3]) && n < 300) begin step(); n++; end
        check_val("t2_timeout", n < 300, 1);
        check_val("t2_cnt", loads_q.size(), 3);
        if (loads_q.size() == 3) begin
            for (int i = 0; i < 3; i++) check_val("t2_byte", loads_q[i], 8'h41 + i);
            for (int i = 1; i < 3; i++)
                check_val("t2_gap", (load_cyc_q[i] - load_cyc_q[i-1]) >= 20, 1);
        end
        check_val("t2_idle", st_do[3], 1);

        // TX full while the core is held busy
        loads_q.delete(); load_cyc_q.delete();
        force_busy = 1;
        for (int i = 0; i < 16; i++) begin
            dat_we = 1; dat_di = 32'hFFFF_FF60 + i; #1;
            check_val("t3_nowait", dat_wait, 0);
            step();
        end
        dat_di = 32'h70; #1;
        check_val("t3_wait", dat_wait, 1);
        check_val("t3_level", st_do[15:8], 16);
        check_val("t3_full", st_do[0], 1);
        step(); step(); step();
        check_val("t3_still_wait", dat_wait, 1);
        force_busy = 0;
        accepted = 0;
        for (int i = 0; i < 40 && !accepted; i++) begin
            if (!dat_wait) accepted = 1;
            step();
        end
        dat_we = 0;
        check_val("t3_accept", accepted, 1);
        n = 0;
        while (!(loads_q.size() == 17 && st_do[3]) && n < 1500) begin step(); n++; end
        check_val("t3_timeout", n < 1500, 1);
        check_val("t3_cnt", loads_q.size(), 17);
        if (loads_q.size() == 17) begin
            for (int i = 0; i < 16; i++) check_val("t3_byte", loads_q[i], 8'h60 + i);
            check_val("t3_last", loads_q[16], 8'h70);
        end

        // RX overrun
        for (int i = 0; i <= 16; i++) begin
            rcvd = 1; rq = 8'(i);
            step();
        end
        rcvd = 0;
        check_val("t4_level", st_do[23:16], 16);
        check_val("t4_ovr", st_do[4], 1);
        check_val("t4_valid", st_do[1], 1);
        for (int i = 0; i < 16; i++) begin
            dat_re = 1; #1;
            check_val("t4_read", dat_do, i);
            step();
        end
        check_val("t4_empty_dat", dat_do, 32'hFFFF_FFFF);
        check_val("t4_empty_valid", st_do[1], 0);
        step();
        dat_re = 0;
        check_val("t4_empty_level", st_do[23:16], 0);
        check_val("t4_ovr_hold", st_do[4], 1);
        st_we = 1; st_di = 32'h10;
        step();
        st_we = 0;
        check_val("t4_ovr_clr", st_do[4], 0);

        // Pop and push on a full RX FIFO in the same cycle
        for (int i = 0; i < 16; i++) begin
            rcvd = 1; rq = 8'hA0 + 8'(i);
            step();
        end
        rcvd = 1; rq = 8'h55; dat_re = 1; #1;
        check_val("t5_head", dat_do, 32'hA0);
        step();
        rcvd = 0; dat_re = 0;
        check_val("t5_level", st_do[23:16], 16);
        check_val("t5_ovr", st_do[4], 0);
        check_val("t5_newhead", dat_do, 32'hA1);
        for (int i = 0; i < 15; i++) begin dat_re = 1; step(); end
        check_val("t5_tail", dat_do, 32'h55);
        dat_re = 1; step(); dat_re = 0;
        check_val("t5_drained", st_do[1], 0);

        // Flush both FIFOs while a byte is in flight
        loads_q.delete(); load_cyc_q.delete();
        for (int i = 0; i < 2; i++) begin rcvd = 1; rq = 8'h11; step(); end
        rcvd = 0;
        for (int i = 0; i < 5; i++) begin dat_we = 1; dat_di = 32'h80 + i; step(); end
        dat_we = 0;
        n = 0;
        while (!txbusy && n < 30) begin step(); n++; end
        check_val("t6_busy_timeout", n < 30, 1);
        step(); step(); step();
        st_we = 1; st_di = 32'h300;
        step();
        st_we = 0;
        check_val("t6_txlvl", st_do[15:8], 0);
        check_val("t6_rxlvl", st_do[23:16], 0);
        check_val("t6_txempty", st_do[2], 1);
        check_val("t6_dat", dat_do, 32'hFFFF_FFFF);
        for (int i = 0; i < 80; i++) step();
        check_val("t6_cnt", loads_q.size(), 1);
        if (loads_q.size() >= 1) check_val("t6_byte", loads_q[0], 8'h80);
        check_val("t6_idle", st_do[3], 1);

        // Randomized traffic against the queue model
        resetn = 0; step(); resetn = 1; step();
        loads_q.delete(); load_cyc_q.delete();
        rxm.delete(); exp_tx.delete(); ovr_m = 0;
        begin
            logic       holding = 0;
            logic [7:0] tx_byte = 0;
            logic [7:0] next_b = 8'h00;
            for (int c = 0; c < 3000; c++) begin
                logic flush, clr, pop, full, ovr_set;
                if ($urandom_range(0, 99) == 0) begin
                    case ($urandom_range(0, 2))
                        0: core_len = 0;
                        1: core_len = 3;
                        default: core_len = 20;
                    endcase
                end
                if (!holding && $urandom_range(0, 15) == 0) begin
                    holding = 1; tx_byte = next_b; next_b++;
                    exp_tx.push_back(tx_byte);
                end
                dat_we = holding;
                dat_di = {$urandom_range(0, 255) << 24 | $urandom_range(0, 65535) << 8} | 32'(tx_byte);
                rcvd   = ($urandom_range(0, 2) == 0);
                rq     = 8'($urandom_range(0, 255));
                dat_re = ($urandom_range(0, 3) == 0);
                st_re  = $urandom_range(0, 1);
                st_we  = ($urandom_range(0, 19) == 0);
                case ($urandom_range(0, 3))
                    0: st_di = 32'h10;
                    1: st_di = 32'h200;
                    2: st_di = 32'h210;
                    default: st_di = 32'hFFFF_FCFF;
                endcase
                @(negedge clk);
                check_val("rnd_dat", dat_do, rxm.size() ? {24'h0, rxm[0]} : 32'hFFFF_FFFF);
                check_val("rnd_rxlvl", st_do[23:16], rxm.size());
                check_val("rnd_valid", st_do[1], rxm.size() != 0);
                check_val("rnd_ovr", st_do[4], ovr_m);
                check_val("rnd_zero", st_do & 32'hFF00_00E0, 0);
                flush = st_we && st_di[9];
                clr   = st_we && st_di[4];
                pop   = dat_re && rxm.size() > 0 && !flush;
                ovr_set = 0;
                if (flush) begin
                    rxm.delete();
                end else begin
                    full = (rxm.size() == 16);
                    if (pop) void'(rxm.pop_front());
                    if (rcvd) begin
                        if (!full || pop) rxm.push_back(rq);
                        else ovr_set = 1;
                    end
                end
                if (ovr_set) ovr_m = 1;
                else if (clr) ovr_m = 0;
                if (holding && !dat_wait) holding = 0;
                step();
            end
            idle_inputs();
            if (holding) begin
                n = 0;
                dat_we = 1; dat_di = 32'(tx_byte);
                while (dat_wait && n < 2000) begin step(); n++; end
                step();
                dat_we = 0;
                check_val("rnd_hold_timeout", n < 2000, 1);
            end
        end
        n = 0;
        while (!(loads_q.size() >= exp_tx.size() && st_do[3]) && n < 20000) begin step(); n++; end
        check_val("rnd_drain_timeout", n < 20000, 1);
        check_val("rnd_tx_cnt", loads_q.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < loads_q.size(); i++)
            check_val("rnd_tx_byte", loads_q[i], exp_tx[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_fifo_ctrl.md
# uart_fifo_ctrl

Buffered register front-end and transmit/receive sequencer for the minimal UART core on the picorv32 peripheral bus. It replaces direct single-byte register access with a TX FIFO drained by a transmit state machine (driving the core's `load`/`d` and observing `txbusy`) and an RX FIFO filled from the core's `bytercvd`/`q`. It also exposes level, empty/full and sticky-overrun status. It sits between the CPU register decode and one UART core instance.

## Interface
- `TX_DEPTH_LOG2`, 4, TX FIFO depth = 2^N entries; legal range 1..7
- `RX_DEPTH_LOG2`, 4, RX FIFO depth = 2^N entries; legal range 1..7
- `clk`  in  1  single system clock; all logic on rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `reg_state_we` / `reg_state_re`  in  1  status/control register write / read strobe
- `reg_state_di`  in  32  control write data
- `reg_state_do`  out  32  status word
- `reg_state_wait`  out  1  constant 0
- `reg_dat_we` / `reg_dat_re`  in  1  data register write (push TX) / read (pop RX) strobe
- `reg_dat_di`  in  32  TX byte in [7:0]; upper bits ignored
- `reg_dat_do`  out  32  RX head byte, or 0xFFFF_FFFF when RX empty
- `reg_dat_wait`  out  1  = `reg_dat_we` && TX full (combinational)
- `uart_load`  out  1  one-cycle load pulse to core
- `uart_d`  out  8  byte presented to core, registered
- `uart_txbusy`  in  1  core transmitter busy
- `uart_bytercvd`  in  1  core one-cycle byte-received pulse
- `uart_q`  in  8  core received byte, valid while `uart_bytercvd` is high

## Operation
- FIFOs: circular buffers with pointers one bit wider than the address; level = wr − rd (mod 2^(N+1)); full when level = 2^N. The head is read combinationally.
- TX push: `reg_dat_we` && !full (full is the pre-edge value) writes `reg_dat_di[7:0]`. While full, `reg_dat_wait` = 1 and nothing is written. The CPU holds the strobe until `reg_dat_wait` drops.
- RX pop: `reg_dat_re` && !empty advances the read pointer. `reg_dat_do` = {24'h0, head} on the same cycle. A read while empty returns 0xFFFF_FFFF and changes nothing.
- RX push: `uart_bytercvd` writes `uart_q` if the RX FIFO is not full, or if it is full and a pop happens in the same cycle. Otherwise the byte is dropped and `rx_overrun` is set (sticky).
- Simultaneous `reg_dat_we` and `reg_dat_re`: both are performed, because the FIFOs are independent. A push and a pop on the same FIFO in the same cycle leave the level unchanged.
- TX FSM states:
  - IDLE: if TX not empty and !`uart_txbusy`, register the head into `uart_d`, pop it, and go to LOAD.
  - LOAD: `uart_load` = 1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: when `uart_txbusy` = 1, go to WAIT_DONE. After 4 cycles without busy, go to IDLE; this guard prevents deadlock.
  - WAIT_DONE: when `uart_txbusy` = 0, go to IDLE.
- Status `reg_state_do`:
  - bit0 tx_full
  - bit1 rx_valid (RX not empty)
  - bit2 tx_empty
  - bit3 tx_idle = tx_empty && FSM IDLE && !`uart_txbusy`
  - bit4 rx_overrun
  - [15:8] TX level
  - [23:16] RX level
  - all other bits 0
- Control write (`reg_state_we`), each action triggered by writing 1 to its bit:
  - bit4: clear rx_overrun. A new overrun in the same cycle wins.
  - bit8: flush TX (rd ← wr). A byte already in LOAD or in flight still completes.
  - bit9: flush RX.
  - A flush has priority over a push or pop to the same FIFO in the same cycle.
- `reg_state_re` has no side effects.

## Timing
- Reset (`resetn` = 0 at an edge) sets:
  - pointers and levels 0; FSM IDLE; rx_overrun 0
  - `uart_load` 0, `uart_d` 0x00
  - `reg_dat_do` 0xFFFF_FFFF
  - `reg_state_do` 0x0000_000C when `uart_txbusy` = 0, else 0x0000_0004
- Reset mid-transmission abandons FSM state. The core finishes its current byte on its own.
- TX latency, with FSM IDLE and the core not busy:
  - push at edge N;
  - IDLE→LOAD at edge N+1;
  - `uart_load` high for the cycle after N+1, with `uart_d` already stable.
- Back-to-back bytes: the next load cannot occur before `uart_txbusy` has risen and fallen (or the WAIT_BUSY guard has expired).
- RX latency: a `uart_bytercvd` pulse sampled at edge M makes the byte visible on `reg_dat_do` and the RX level +1 immediately after M.
- Status reflects pointer and flag state after the most recent edge. No additional pipeline stage.

## Test plan
- Reset, then idle with `uart_txbusy` = 0 -> `reg_state_do` = 0x0000_000C; `reg_dat_do` = 0xFFFF_FFFF; `uart_load` never asserts.
- Write 0x41, 0x42, 0x43 back-to-back; the core model raises busy 1 cycle after load for 20 cycles -> exactly three `uart_load` pulses with `uart_d` = 0x41, 0x42, 0x43 in order, each ≥ 20 cycles apart; tx_idle returns to 1.
- Hold `uart_txbusy` = 1 and write 17 bytes (depth 16) -> the 17th write sees `reg_dat_wait` = 1 and status [15:8] = 16, bit0 = 1; releasing busy drains the FIFO and the 17th write then completes.
- Inject 17 `bytercvd` pulses (0x00..0x10) with no reads -> RX level 16, bit4 = 1; reads return 0x00..0x0F, then 0xFFFF_FFFF; writing 0x10 to the state register clears bit4.
- With RX full, assert `bytercvd` (0x55) in the same cycle as `reg_dat_re` -> the head pops, 0x55 is accepted at the tail, level stays 16, and no overrun is flagged.
- Queue 5 TX bytes and write 0x300 to the state register during WAIT_DONE -> both FIFOs are empty, the in-flight byte completes, and no further `uart_load` occurs.
